r2_reader: RTL and testbench
============================

R2_READER -- requirements
Module: r2_reader

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning RAM address width.
REQ-002 The block SHALL have parameter M, default 4, meaning RAM data width.
REQ-003 timer555  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a readout burst; sampled in IDLE only.
REQ-006 base_addr  input  N  first RAM address of the burst; sampled with start.
REQ-007 length  input  N+1  number of words to read, 0..2^N; sampled with start.
REQ-008 mem_addr  output  N  RAM read address.
REQ-009 mem_rd  output  1  RAM read strobe.
REQ-010 mem_data  input  M  RAM read data, valid exactly one cycle after the cycle mem_rd is high.
REQ-011 out_data  output  M  registered output word.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream accepts out_data when high together with out_valid.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse marking burst end.

Function
REQ-016 The FSM SHALL have states IDLE, READ, WAIT, HOLD, DONE.
REQ-017 IDLE with start=1 and length>0 SHALL load the address counter with base_addr and the remaining count with length, then go to READ.
REQ-018 IDLE with start=1 and length=0 SHALL go directly to DONE; no mem_rd is issued.
REQ-019 READ SHALL drive mem_rd=1 and mem_addr=current address for exactly one cycle, then go to WAIT.
REQ-020 WAIT SHALL capture mem_data into out_data, set out_valid=1 and decrement the remaining count, then go to HOLD.
REQ-021 HOLD SHALL keep out_data and out_valid stable until out_valid and out_ready are both high at a rising edge.
REQ-022 On that handshake, out_valid SHALL clear. If the remaining count is nonzero, the address SHALL increment and the FSM SHALL go to READ; otherwise it SHALL go to DONE.
REQ-023 Address increment SHALL wrap modulo 2^N, so address 3 is followed by 0 for N=2.
REQ-024 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-025 Minimum throughput SHALL be one word per 3 cycles. Latency from the start edge to the first out_valid SHALL be 2 cycles.
REQ-026 start while busy=1 SHALL be ignored without side effects.
REQ-027 mem_rd SHALL be 0 in every state except READ. mem_addr SHALL hold its last value outside READ.
REQ-028 length=2^N SHALL read every location exactly once, starting at base_addr.

Reset
REQ-029 On reset_n=0, and on any reset asserted mid-burst, the FSM SHALL enter IDLE immediately. mem_addr, out_data and the remaining count SHALL be 0. mem_rd, out_valid, busy and done SHALL be 0.
REQ-030 After reset_n deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-031 Package r2_pkg SHALL hold N, M and the FSM state enumeration, shared with R2.
REQ-032 The address counter SHALL be a sub-module, r2_addr_counter: a loadable, wrapping N-bit up-counter with load and inc enables.
REQ-033 The remaining count and the output register SHALL be inline in r2_reader.
REQ-034 Target size SHALL be 120-400 lines of RTL.

Verification
All scenarios use a RAM model preloaded with addr0=0001, addr1=0010, addr2=0100, addr3=1000.
REQ-035 Full burst: base_addr=0, length=4, out_ready=1. Required: out_data stream 0001, 0010, 0100, 1000; done pulses once, one cycle after the 4th handshake; exactly 4 mem_rd pulses.
REQ-036 Wrap: base_addr=3, length=2. Required: mem_addr 3 then 0; outputs 1000, 0001.
REQ-037 Backpressure: base_addr=1, length=2, out_ready=0 for 10 cycles. Required: out_data=0010 and out_valid=1 held stable, no further mem_rd. Then raise out_ready. Required: 0100 follows.
REQ-038 Zero length: start with length=0. Required: busy=1 for exactly one cycle (the DONE cycle) with done=1, no mem_rd, out_valid stays 0.
REQ-039 Ignored start: second start with base_addr=2 mid-burst. Required: the original sequence is unchanged.
REQ-040 Mid-burst reset: assert reset_n=0 in HOLD. Required: out_valid, busy, mem_rd = 0 immediately. A new start afterwards SHALL complete correctly.

Source files
------------

// File: rtl/r2_pkg.sv
// Shared parameters and FSM state encoding for the R2 RAM readout block.
// Imported by r2_reader and r2_addr_counter.
package r2_pkg;
  localparam int N = 2;
  localparam int M = 4;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    HOLD,
    DONE
  } state_t;
endpackage

// File: rtl/r2_addr_counter.sv
// Loadable, wrapping N-bit up-counter used as the RAM read address.
// Ports: i_clk, i_rst_n, i_load, i_inc, i_base (load value), o_addr.
module r2_addr_counter #(
  parameter int N = r2_pkg::N
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_inc,
  input  logic [N-1:0] i_base,
  output logic [N-1:0] o_addr
);

  logic [N-1:0] r_addr;

  // Increment relies on natural N-bit overflow for the wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
    end else if (i_inc) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/r2_reader.sv
// RAM burst reader: fetches length words from base_addr into a handshaked
// output register. Ports: timer555/reset_n, start/base_addr/length request,
// mem_addr/mem_rd/mem_data RAM side, out_data/out_valid/out_ready stream,
// busy and done status.
module r2_reader #(
  parameter int N = r2_pkg::N,
  parameter int M = r2_pkg::M
) (
  input  logic         timer555,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] base_addr,
  input  logic [N:0]   length,
  output logic [N-1:0] mem_addr,
  output logic         mem_rd,
  input  logic [M-1:0] mem_data,
  output logic [M-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  import r2_pkg::*;

  state_t       r_state;
  logic [N:0]   r_rem;
  logic [M-1:0] r_data;
  logic         r_valid;
  logic         r_rd;
  logic         r_busy;
  logic         r_done;

  logic         w_start_ok;
  logic         w_hs;
  logic         w_more;
  logic         w_load;
  logic         w_inc;
  logic [N-1:0] w_addr;

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_hs       = (r_state == HOLD) && r_valid && out_ready;
  assign w_more     = (r_rem != '0);
  assign w_load     = w_start_ok && (length != '0);
  assign w_inc      = w_hs && w_more;

  r2_addr_counter #(
    .N (N)
  ) u_addr (
    .i_clk   (timer555),
    .i_rst_n (reset_n),
    .i_load  (w_load),
    .i_inc   (w_inc),
    .i_base  (base_addr),
    .o_addr  (w_addr)
  );

  // Strobes are set on the transition into the state they belong to,
  // so mem_rd/done/busy are registered and line up with the state.
  always_ff @(posedge timer555 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_rd    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rd   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (length != '0) begin
              r_rem   <= length;
              r_rd    <= 1'b1;
              r_state <= READ;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        READ: begin
          r_state <= WAIT;
        end
        WAIT: begin
          r_data  <= mem_data;
          r_valid <= 1'b1;
          r_rem   <= r_rem - 1'b1;
          r_state <= HOLD;
        end
        HOLD: begin
          if (r_valid && out_ready) begin
            r_valid <= 1'b0;
            if (w_more) begin
              r_rd    <= 1'b1;
              r_state <= READ;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = w_addr;
  assign mem_rd    = r_rd;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_r2_reader.sv
// Directed self-checking bench for r2_reader with a 1-cycle-latency RAM.
// RAM preload: addr0=0001 addr1=0010 addr2=0100 addr3=1000.
module tb_r2_reader;

  localparam int N = 2;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] base_addr = '0;
  logic [N:0]   length = '0;
  logic [N-1:0] mem_addr;
  logic         mem_rd;
  logic [M-1:0] mem_data = '0;
  logic [M-1:0] out_data;
  logic         out_valid;
  logic         busy;
  logic         done;

  logic [M-1:0] ram [4];
  logic [M-1:0] out_q [$];
  logic [N-1:0] addr_q [$];
  int rd_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int done_cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  r2_reader #(
    .N (N),
    .M (M)
  ) dut (
    .timer555  (clk),
    .reset_n   (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always @(posedge clk) begin
    cyc = cyc + 1;
    mem_data <= mem_rd ? ram[mem_addr] : '0;
    if (mem_rd) begin
      rd_cnt = rd_cnt + 1;
      addr_q.push_back(mem_addr);
    end
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      hs_cyc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e [4],
                         input int n);
    chk({tag, "_cnt"}, out_q.size(), n);
    for (int i = 0; i < n; i++)
      chk(tag, (i < out_q.size()) ? {28'd0, out_q[i]} : 32'hdead, e[i]);
  endtask

  task automatic chk_addr(input string tag, input logic [1:0] e [4],
                          input int n);
    chk({tag, "_cnt"}, addr_q.size(), n);
    for (int i = 0; i < n; i++)
      chk(tag, (i < addr_q.size()) ? {30'd0, addr_q[i]} : 32'hdead, e[i]);
  endtask

  task automatic clr();
    out_q.delete();
    addr_q.delete();
    rd_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic go(input logic [N-1:0] b, input logic [N:0] l);
    base_addr = b;
    length = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    ram[0] = 4'b0001;
    ram[1] = 4'b0010;
    ram[2] = 4'b0100;
    ram[3] = 4'b1000;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // full burst, start on first edge after reset release
    rst_n = 1'b1;
    clr();
    out_ready = 1'b1;
    go(2'd0, 3'd4);
    chk("fb_rd", mem_rd, 1);
    chk("fb_addr", mem_addr, 0);
    chk("fb_busy", busy, 1);
    chk("fb_valid0", out_valid, 0);
    @(negedge clk);
    chk("fb_wait_rd", mem_rd, 0);
    chk("fb_wait_valid", out_valid, 0);
    @(negedge clk);
    chk("fb_lat_valid", out_valid, 1);
    chk("fb_lat_data", out_data, 4'b0001);
    wait_idle("fb_timeout");
    chk_out("fb_out", '{4'b0001, 4'b0010, 4'b0100, 4'b1000}, 4);
    chk_addr("fb_maddr", '{2'd0, 2'd1, 2'd2, 2'd3}, 4);
    chk("fb_rdcnt", rd_cnt, 4);
    chk("fb_donecnt", done_cnt, 1);
    chk("fb_donepos", done_cyc, hs_cyc + 1);
    chk("fb_idle_done", done, 0);

    // wrap
    clr();
    go(2'd3, 3'd2);
    wait_idle("wr_timeout");
    chk_addr("wr_maddr", '{2'd3, 2'd0, 2'd0, 2'd0}, 2);
    chk_out("wr_out", '{4'b1000, 4'b0001, 4'b0, 4'b0}, 2);
    chk("wr_donecnt", done_cnt, 1);

    // backpressure
    clr();
    out_ready = 1'b0;
    go(2'd1, 3'd2);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_data", out_data, 4'b0010);
      chk("bp_valid", out_valid, 1);
      @(negedge clk);
    end
    chk("bp_rdcnt", rd_cnt, 1);
    out_ready = 1'b1;
    wait_idle("bp_timeout");
    chk_out("bp_out", '{4'b0010, 4'b0100, 4'b0, 4'b0}, 2);
    chk("bp_rdcnt2", rd_cnt, 2);

    // zero length
    clr();
    go(2'd2, 3'd0);
    chk("zl_busy", busy, 1);
    chk("zl_done", done, 1);
    chk("zl_rd", mem_rd, 0);
    chk("zl_valid", out_valid, 0);
    @(negedge clk);
    chk("zl_busy_end", busy, 0);
    chk("zl_done_end", done, 0);
    chk("zl_rdcnt", rd_cnt, 0);
    chk("zl_donecnt", done_cnt, 1);

    // ignored start mid-burst
    clr();
    go(2'd0, 3'd4);
    repeat (3) @(negedge clk);
    go(2'd2, 3'd1);
    wait_idle("ig_timeout");
    chk_out("ig_out", '{4'b0001, 4'b0010, 4'b0100, 4'b1000}, 4);
    chk_addr("ig_maddr", '{2'd0, 2'd1, 2'd2, 2'd3}, 4);
    chk("ig_donecnt", done_cnt, 1);

    // mid-burst reset in HOLD
    clr();
    out_ready = 1'b0;
    go(2'd0, 3'd4);
    repeat (2) @(negedge clk);
    chk("mr_hold_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rd", mem_rd, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    out_ready = 1'b1;
    go(2'd2, 3'd2);
    wait_idle("mr_timeout");
    chk_out("mr_out", '{4'b0100, 4'b1000, 4'b0, 4'b0}, 2);
    chk("mr_donecnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
